fpu_addsub_pipe: RTL and testbench
==================================

# fpu_addsub_pipe

Parametrised floating-point add/subtract unit for the Zuse-style number format: sign, two's-complement exponent and explicit-leading-one mantissa. Generalises the fixed 7/15-bit adder with:
- configurable exponent and mantissa widths;
- a valid/ready operand and result handshake;
- magnitude-correct sign selection;
- explicit zero handling;
- exponent overflow and underflow detection with saturation or flush.

It sits between the register file and the datapath sequencer and accepts one operation at a time.

## Interface
- EXP_W, 7, exponent width, two's complement, range -2^(EXP_W-1) .. 2^(EXP_W-1)-1
- MAN_W, 15, mantissa width; bit MAN_W-1 has weight 1.0; value = (-1)^s · m/2^(MAN_W-1) · 2^e
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- op  in  1  0 = a+b, 1 = a−b
- a_s, b_s  in  1  operand signs
- a_e, b_e  in  EXP_W  operand exponents
- a_m, b_m  in  MAN_W  operand mantissas
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer accepts result
- res_s  out  1  result sign
- res_e  out  EXP_W  result exponent
- res_m  out  MAN_W  result mantissa
- res_zero  out  1  result is zero
- res_ovf  out  1  exponent overflow, result saturated
- res_unf  out  1  exponent underflow, result flushed to zero

## Operation
- **States:** IDLE → ALIGN → ADD → NORM → DONE → IDLE. Encoding is free; unused codes go to IDLE.
- **IDLE:** on in_valid & in_ready, capture all operands. Set b_s_eff = b_s ^ op. Operands may change after the capture edge.
- **ALIGN:**
  - Zero operand: m == 0, exponent ignored.
  - Form diff = a_e − b_e in EXP_W+1 bits.
  - Larger operand L: larger exponent wins; on a tie, the larger mantissa wins; on a full tie, L = a.
  - Smaller operand S is right-shifted by |diff| in an (MAN_W+2)-bit work field, truncating shifted-out bits.
  - If |diff| > MAN_W+1, S contributes 0.
- **ADD:**
  - effsub = L_s ^ S_s_eff.
  - Work sum = L_m ± S_m_aligned; never negative, because L ≥ S.
  - Working exponent = L_e, sign-extended to EXP_W+2 bits.
- **NORM:**
  - Carry into bit MAN_W: shift right 1 (truncate), exponent +1.
  - Otherwise left-shift until bit MAN_W-1 = 1; exponent decreases by the shift count. This uses a priority encoder over all MAN_W bits.
  - Unnormalised nonzero inputs are therefore normalised too.
- **Zero cases:**
  - Work sum zero (including exact cancellation and both operands zero): res_m = 0, res_e = 0, res_s = 0, res_zero = 1.
  - One operand zero: result equals the other operand with its effective sign, bit-exact.
- **Sign:** res_s = L's effective sign.
- **Overflow:** exponent > max → res_e = max, res_m = all ones, res_ovf = 1, sign kept.
- **Underflow:** exponent < min → res_m = 0, res_e = 0, res_s = 0, res_zero = 1, res_unf = 1.
- **DONE:** out_valid = 1; result and flags stable until out_valid & out_ready.

## Timing
- **Reset values:**
  - Asynchronous; state = IDLE.
  - out_valid, res_s, res_e, res_m, res_zero, res_ovf and res_unf = 0.
  - in_ready = 1 from reset assertion onward, since it is combinational from state.
- **Latency:** accepting edge k; out_valid rises after edge k+3 (ALIGN at k+1, ADD at k+2, NORM at k+3). It stays high through any out_ready stall.
- **Result transfer:** on the edge with out_valid & out_ready, out_valid falls and state returns to IDLE. in_ready is high in the following cycle; no same-cycle back-to-back.
- **in_valid outside IDLE:** ignored, with no queuing.
- **Reset mid-operation:** result is discarded, outputs go to reset values, and no out_valid is produced for the aborted operation.
- **Result registers:** they hold the last result after the transfer until the next NORM overwrites them.

## Test plan
- **1.0 + 1.0** (defaults; a: e=0, m=0x4000; b: same; op=0) → out_valid 3 edges after accept; s=0, e=1, m=0x4000, all flags 0.
- **1.0 − 1.5** (a: e=0, m=0x4000; b: e=0, m=0x6000; op=1) → s=1, e=0x7F (−1), m=0x4000. Then 1.0 − 1.0 → s=0, e=0, m=0, res_zero=1.
- **Overflow:** e=63, m=0x4000 twice with op=0 → res_ovf=1, e=63, m=0x7FFF, s=0.
- **Underflow:** a: e=−64, m=0x6000; b: e=−64, m=0x4000; op=1 → res_unf=1, res_zero=1, e=0, m=0, s=0.
- **Alignment beyond width:** a = 1.0; b: e=−20, m=0x7FFF; op=0 → result bit-exact 1.0. With operands swapped and op=1 → s=1, e=0, m=0x4000.
- **Handshake and reset:**
  - Hold out_ready=0 for 5 cycles: result and out_valid stable, in_valid pulses ignored.
  - Assert reset during ALIGN: out_valid stays 0, in_ready=1 immediately.
  - After release, a new 1.0+1.0 completes correctly.

Source files
------------

// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: multi-cycle sign/two's-complement-exponent/explicit-one mantissa add/subtract with valid/ready handshake
module fpu_addsub_pipe #(
  parameter int EXP_W = 7,
  parameter int MAN_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             a_s,
  input  logic             b_s,
  input  logic [EXP_W-1:0] a_e,
  input  logic [EXP_W-1:0] b_e,
  input  logic [MAN_W-1:0] a_m,
  input  logic [MAN_W-1:0] b_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_s,
  output logic [EXP_W-1:0] res_e,
  output logic [MAN_W-1:0] res_m,
  output logic             res_zero,
  output logic             res_ovf,
  output logic             res_unf
);
  localparam int WW = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MIN = ~E_MAX;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state;
  logic ra_s, rb_s, l_s, s_s, byp;
  logic [EXP_W-1:0] ra_e, rb_e, l_e;
  logic [MAN_W-1:0] ra_m, rb_m, l_m, n_m;
  logic [WW-1:0] s_al, sum;
  logic signed [EW-1:0] w_e, n_e;
  logic [EW-1:0] sh;
  logic [EXP_W:0] diff, ad;
  logic a_z, b_z, a_big, z, ovf, unf;
  assign in_ready = state == IDLE;
  assign a_z = ra_m == '0;
  assign b_z = rb_m == '0;
  assign diff = {ra_e[EXP_W-1], ra_e} - {rb_e[EXP_W-1], rb_e};
  assign ad = diff[EXP_W] ? -diff : diff;
  // A zero operand never wins, so the nonzero one passes through untouched
  assign a_big = b_z || (!a_z && ($signed(ra_e) > $signed(rb_e) || (ra_e == rb_e && ra_m >= rb_m)));
  always_comb begin
    sh = '0;
    for (int i = 0; i < MAN_W; i++)
      if (sum[i]) sh = EW'(MAN_W - 1 - i);
    n_e = sum[MAN_W] ? w_e + EW'(1) : w_e - sh;
    n_m = sum[MAN_W] ? sum[MAN_W:1] : MAN_W'(sum << sh);
    z   = byp ? l_m == '0 : sum == '0;
    ovf = !byp && !z && n_e > E_MAX;
    unf = !byp && !z && n_e < E_MIN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      {res_s, res_e, res_m, res_zero, res_ovf, res_unf} <= '0;
      {ra_s, ra_e, ra_m, rb_s, rb_e, rb_m} <= '0;
      {l_s, l_e, l_m, s_s, s_al, byp, sum, w_e} <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {ra_s, ra_e, ra_m} <= {a_s, a_e, a_m};
          {rb_s, rb_e, rb_m} <= {b_s ^ op, b_e, b_m};
          state <= ALIGN;
        end
        ALIGN: begin
          l_s  <= a_big ? ra_s : rb_s;
          l_e  <= a_big ? ra_e : rb_e;
          l_m  <= a_big ? ra_m : rb_m;
          s_s  <= a_big ? rb_s : ra_s;
          s_al <= WW'(a_big ? rb_m : ra_m) >> ad;
          byp  <= a_z || b_z;
          state <= ADD;
        end
        ADD: begin
          sum <= (l_s ^ s_s) ? WW'(l_m) - s_al : WW'(l_m) + s_al;
          w_e <= {{2{l_e[EXP_W-1]}}, l_e};
          state <= NORM;
        end
        NORM: begin
          res_s    <= !z && !unf && l_s;
          res_e    <= (z || unf) ? '0 : ovf ? E_MAX[EXP_W-1:0] : byp ? l_e : n_e[EXP_W-1:0];
          res_m    <= (z || unf) ? '0 : ovf ? '1 : byp ? l_m : n_m;
          res_zero <= z || unf;
          res_ovf  <= ovf;
          res_unf  <= unf;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe: directed self-checking bench for fpu_addsub_pipe
module tb_fpu_addsub_pipe;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, op = 0;
  logic a_s = 0, b_s = 0, out_valid, out_ready = 0;
  logic [6:0] a_e = 0, b_e = 0, res_e;
  logic [14:0] a_m = 0, b_m = 0, res_m;
  logic res_s, res_zero, res_ovf, res_unf;
  logic [25:0] res;
  int checks = 0, fails = 0, lat;
  assign res = {res_s, res_e, res_m, res_zero, res_ovf, res_unf};
  always #5 clk = ~clk;
  fpu_addsub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_s(a_s), .b_s(b_s), .a_e(a_e), .b_e(b_e), .a_m(a_m), .b_m(b_m),
    .out_valid(out_valid), .out_ready(out_ready), .res_s(res_s), .res_e(res_e),
    .res_m(res_m), .res_zero(res_zero), .res_ovf(res_ovf), .res_unf(res_unf)
  );
  task automatic issue(input logic o, input logic as, input logic [6:0] ae, input logic [14:0] am,
                       input logic bs, input logic [6:0] be, input logic [14:0] bm);
    int n;
    @(negedge clk);
    {op, a_s, a_e, a_m, b_s, b_e, b_m} = {o, as, ae, am, bs, be, bm};
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 20);
    lat = out_valid ? n : -1;
  endtask
  task automatic take();
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  task automatic test_reset();
    #1 checks++;
    if ({out_valid, res, in_ready} !== {1'b0, 26'd0, 1'b1}) begin
      fails++; $display("FAIL reset: got %h required %h", {out_valid, res, in_ready}, {1'b0, 26'd0, 1'b1});
    end
    @(negedge clk) reset = 0;
  endtask
  task automatic test_add();
    issue(0, 0, 7'd0, 15'h4000, 0, 7'd0, 15'h4000);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL add_latency: got %0d required 3", lat); end
    checks++;
    if (res !== {1'b0, 7'd1, 15'h4000, 3'b000}) begin
      fails++; $display("FAIL add_1p1: got %h required %h", res, {1'b0, 7'd1, 15'h4000, 3'b000});
    end
    take();
    checks++;
    if ({out_valid, in_ready, res_m} !== {1'b0, 1'b1, 15'h4000}) begin
      fails++; $display("FAIL add_transfer: got %h required %h", {out_valid, in_ready, res_m}, {1'b0, 1'b1, 15'h4000});
    end
  endtask
  task automatic test_sub();
    issue(1, 0, 7'd0, 15'h4000, 0, 7'd0, 15'h6000);
    checks++;
    if (res !== {1'b1, 7'h7F, 15'h4000, 3'b000}) begin
      fails++; $display("FAIL sub_1m1p5: got %h required %h", res, {1'b1, 7'h7F, 15'h4000, 3'b000});
    end
    take();
    issue(1, 0, 7'd0, 15'h4000, 0, 7'd0, 15'h4000);
    checks++;
    if (res !== {1'b0, 7'd0, 15'h0, 3'b100}) begin
      fails++; $display("FAIL sub_cancel: got %h required %h", res, {1'b0, 7'd0, 15'h0, 3'b100});
    end
    take();
    issue(1, 0, 7'd0, 15'h4000, 0, 7'h7F, 15'h4000);
    checks++;
    if (res !== {1'b0, 7'h7F, 15'h4000, 3'b000}) begin
      fails++; $display("FAIL sub_1m0p5: got %h required %h", res, {1'b0, 7'h7F, 15'h4000, 3'b000});
    end
    take();
    issue(1, 0, 7'd50, 15'h0, 0, 7'd2, 15'h6000);
    checks++;
    if (res !== {1'b1, 7'd2, 15'h6000, 3'b000}) begin
      fails++; $display("FAIL zero_operand: got %h required %h", res, {1'b1, 7'd2, 15'h6000, 3'b000});
    end
    take();
  endtask
  task automatic test_ovf();
    issue(0, 0, 7'd63, 15'h4000, 0, 7'd63, 15'h4000);
    checks++;
    if (res !== {1'b0, 7'd63, 15'h7FFF, 3'b010}) begin
      fails++; $display("FAIL overflow: got %h required %h", res, {1'b0, 7'd63, 15'h7FFF, 3'b010});
    end
    take();
  endtask
  task automatic test_unf();
    issue(1, 0, 7'h40, 15'h6000, 0, 7'h40, 15'h4000);
    checks++;
    if (res !== {1'b0, 7'd0, 15'h0, 3'b101}) begin
      fails++; $display("FAIL underflow: got %h required %h", res, {1'b0, 7'd0, 15'h0, 3'b101});
    end
    take();
  endtask
  task automatic test_align();
    issue(0, 0, 7'd0, 15'h4000, 0, 7'h6C, 15'h7FFF);
    checks++;
    if (res !== {1'b0, 7'd0, 15'h4000, 3'b000}) begin
      fails++; $display("FAIL align_far: got %h required %h", res, {1'b0, 7'd0, 15'h4000, 3'b000});
    end
    take();
    issue(1, 0, 7'h6C, 15'h7FFF, 0, 7'd0, 15'h4000);
    checks++;
    if (res !== {1'b1, 7'd0, 15'h4000, 3'b000}) begin
      fails++; $display("FAIL align_swap: got %h required %h", res, {1'b1, 7'd0, 15'h4000, 3'b000});
    end
    take();
  endtask
  task automatic test_stall();
    issue(0, 0, 7'd0, 15'h4000, 0, 7'd0, 15'h4000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {op, a_e, a_m, b_m} = {1'b1, 7'd3, 15'h5555, 15'h1234};
      in_valid = (i % 2) == 0;
      @(posedge clk);
      #1 checks++;
      if ({out_valid, res} !== {1'b1, 1'b0, 7'd1, 15'h4000, 3'b000}) begin
        fails++; $display("FAIL stall_%0d: got %h required %h", i, {out_valid, res}, {1'b1, 1'b0, 7'd1, 15'h4000, 3'b000});
      end
    end
    @(negedge clk) in_valid = 0;
    take();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL no_queue_%0d: got %b required 0", i, out_valid); end
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    {op, a_s, a_e, a_m, b_s, b_e, b_m} = {1'b0, 1'b0, 7'd0, 15'h4000, 1'b0, 7'd0, 15'h4000};
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    reset = 1;
    #1 checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++; $display("FAIL reset_mid: got %b required 10", {in_ready, out_valid});
    end
    @(posedge clk);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        fails++; $display("FAIL abort_%0d: got %b required 01", i, {out_valid, in_ready});
      end
    end
    issue(0, 0, 7'd0, 15'h4000, 0, 7'd0, 15'h4000);
    checks++;
    if ({lat[3:0], res} !== {4'd3, 1'b0, 7'd1, 15'h4000, 3'b000}) begin
      fails++; $display("FAIL after_reset: got %h required %h", {lat[3:0], res}, {4'd3, 1'b0, 7'd1, 15'h4000, 3'b000});
    end
    take();
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_unf();
    test_align();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
